// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write port of the encoder/loader.
// master = stimulus/host side, slave = loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I fields into R/I/S/U words and streams them into instruction memory.
// Optional INSTR_ENC_CHECK_EN: drop bundles whose opcode[1:0] != 2'b11 and flag err.
module instr_encoder_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        word_count,
    output logic                   done,
    output logic                   full,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept, legal, write, at_end, finish, start_ok;

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            2'b00:   w = {funct7, rs2, rs1, funct3, rd, opcode};
            2'b01:   w = {imm[11:0], rs1, funct3, rd, opcode};
            2'b10:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            default: w = {imm[31:12], rd, opcode};
        endcase
        return w;
    endfunction

    assign bus.in_ready = (state == LOAD) && !full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign start_ok     = start && (state != LOAD);
`ifdef INSTR_ENC_CHECK_EN
    assign legal        = (bus.opcode[1:0] == 2'b11);
`else
    assign legal        = 1'b1;
`endif
    assign write        = accept && legal;
    assign at_end       = write && (wr_ptr == ADDR_W'(DEPTH - 1));
    // A rejected bundle carrying in_last still closes the session.
    assign finish       = accept && (bus.in_last || at_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)  state_nxt = LOAD;
            LOAD:       if (finish) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            wr_ptr        <= '0;
            word_count    <= '0;
            done          <= 1'b0;
            full          <= 1'b0;
        end else begin
            bus.mem_we <= write;
            done       <= finish;
            if (start_ok) begin
                wr_ptr     <= '0;
                word_count <= '0;
                full       <= 1'b0;
            end else if (write) begin
                bus.mem_addr  <= wr_ptr;
                bus.mem_wdata <= encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                                        bus.funct3, bus.funct7, bus.imm);
                wr_ptr        <= wr_ptr + ADDR_W'(1);
                word_count    <= word_count + (ADDR_W + 1)'(1);
                if (at_end) full <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err <= 1'b0;
        else if (start_ok)          err <= 1'b0;
        else if (accept && !legal)  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encodings, back-to-back streaming, fill-to-full on a DEPTH=4 copy,
// async reset mid-stream, and the opcode check when INSTR_ENC_CHECK_EN is defined.
module tb_instr_encoder_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start4;
    logic [6:0] word_count;
    logic [2:0] word_count4;
    logic       done, full, err, done4, full4, err4;
    int         n_cmp = 0;
    int         n_bad = 0;

    instr_encoder_loader_if #(.ADDR_W(6)) b ();
    instr_encoder_loader_if #(.ADDR_W(2)) q ();

    instr_encoder_loader #(.DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(b.slave),
        .word_count(word_count), .done(done), .full(full), .err(err)
    );

    instr_encoder_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bus(q.slave),
        .word_count(word_count4), .done(done4), .full(full4), .err(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic last);
        b.fmt = fmt; b.opcode = opc; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.funct3 = f3; b.funct7 = f7; b.imm = imm; b.in_last = last; b.in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  nacc, nwr;
        logic rdy;
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        b.in_valid = 1'b0; b.in_last = 1'b0; b.fmt = '0; b.opcode = '0; b.rd = '0;
        b.rs1 = '0; b.rs2 = '0; b.funct3 = '0; b.funct7 = '0; b.imm = '0;
        q.in_valid = 1'b0; q.in_last = 1'b0; q.fmt = 2'b00; q.opcode = 7'h33; q.rd = '0;
        q.rs1 = '0; q.rs2 = '0; q.funct3 = '0; q.funct7 = '0; q.imm = '0;
        tick(); tick();

        chk("rst_in_ready", b.in_ready, 0);
        chk("rst_mem_we", b.mem_we, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        chk("rst_mem_wdata", b.mem_wdata, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", b.in_ready, 0);

        // Session 1: two back-to-back R-type words, second is last
        pulse_start();
        chk("start_in_ready", b.in_ready, 1);
        put(2'b00, 7'h33, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0, 1'b0);
        tick();
        chk("r1_we", b.mem_we, 1);
        chk("r1_addr", b.mem_addr, 0);
        chk("r1_wdata", b.mem_wdata, 32'h01CE0333);
        chk("r1_wc", word_count, 1);
        chk("r1_done", done, 0);
        chk("r1_ready", b.in_ready, 1);
        put(2'b00, 7'h33, 5'd6, 5'd28, 5'd6, 3'd0, 7'd0, 32'd0, 1'b1);
        tick();
        chk("r2_we", b.mem_we, 1);
        chk("r2_addr", b.mem_addr, 1);
        chk("r2_wdata", b.mem_wdata, 32'h006E0333);
        chk("r2_done", done, 1);
        chk("r2_ready", b.in_ready, 0);
        chk("r2_wc", word_count, 2);
        b.in_valid = 1'b0;
        tick();
        chk("r2_we_drop", b.mem_we, 0);
        chk("r2_done_drop", done, 0);

        // Session 2: I, S (negative imm), R sub, U
        pulse_start();
        chk("s2_wc_clear", word_count, 0);
        put(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        tick();
        chk("i_wdata", b.mem_wdata, 32'h00500093);
        chk("i_addr", b.mem_addr, 0);
        chk("i_wc", word_count, 1);
        b.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load_wc", word_count, 1);
        chk("start_in_load_we", b.mem_we, 0);
        chk("start_in_load_ready", b.in_ready, 1);
        put(2'b10, 7'h23, 5'd31, 5'd2, 5'd5, 3'd2, 7'h7F, 32'hFFFF_FFFC, 1'b0);
        tick();
        chk("s_wdata", b.mem_wdata, 32'hFE512E23);
        chk("s_addr", b.mem_addr, 1);
        put(2'b00, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("sub_wdata", b.mem_wdata, 32'h402081B3);
        put(2'b11, 7'h37, 5'd10, 5'd7, 5'd7, 3'd7, 7'h7F, 32'h1234_5FFF, 1'b1);
        tick();
        chk("u_wdata", b.mem_wdata, 32'h12345537);
        chk("u_addr", b.mem_addr, 3);
        chk("u_done", done, 1);
        chk("u_full", full, 0);
        b.in_valid = 1'b0;
        tick();

        // Async reset while a write is on the port
        pulse_start();
        put(2'b00, 7'h33, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0, 1'b0);
        tick();
        chk("mid_we_before", b.mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", b.mem_we, 0);
        chk("mid_rst_addr", b.mem_addr, 0);
        chk("mid_rst_wdata", b.mem_wdata, 0);
        chk("mid_rst_wc", word_count, 0);
        chk("mid_rst_ready", b.in_ready, 0);
        b.in_valid = 1'b0;
        tick();
        chk("mid_rst_no_write", b.mem_we, 0);
        rst_n = 1'b1;
        tick();
        pulse_start();
        put(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        tick();
        chk("post_rst_addr", b.mem_addr, 0);
        chk("post_rst_wdata", b.mem_wdata, 32'h00500093);
        chk("post_rst_we", b.mem_we, 1);
        b.in_valid = 1'b0;
        tick();

`ifdef INSTR_ENC_CHECK_EN
        pulse_start();
        put(2'b00, 7'h30, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0, 1'b0);
        tick();
        chk("chk_bad_we", b.mem_we, 0);
        chk("chk_bad_err", err, 1);
        chk("chk_bad_wc", word_count, 0);
        put(2'b00, 7'h33, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0, 1'b1);
        tick();
        chk("chk_good_we", b.mem_we, 1);
        chk("chk_good_addr", b.mem_addr, 0);
        chk("chk_err_sticky", err, 1);
        b.in_valid = 1'b0;
        tick();
        pulse_start();
        chk("chk_err_clear", err, 0);
        put(2'b00, 7'h30, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        tick();
        chk("chk_bad_last_done", done, 1);
        chk("chk_bad_last_we", b.mem_we, 0);
        b.in_valid = 1'b0;
        tick();
`else
        pulse_start();
        put(2'b00, 7'h30, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0, 1'b1);
        tick();
        chk("nochk_we", b.mem_we, 1);
        chk("nochk_wdata", b.mem_wdata, 32'h01CE0330);
        chk("nochk_err", err, 0);
        b.in_valid = 1'b0;
        tick();
`endif

        // DEPTH=4: five bundles offered, four land, full + done on the fourth
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        nacc = 0;
        nwr  = 0;
        q.rd = 5'd0;
        q.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rdy = q.in_ready;
            tick();
            if (rdy) begin
                nacc++;
                q.rd = 5'(nacc);
            end
            if (q.mem_we) begin
                chk("d4_addr", q.mem_addr, 64'(nwr));
                chk("d4_wdata", q.mem_wdata, 64'((nwr << 7) | 32'h33));
                chk("d4_full", full4, (nwr == 3) ? 1 : 0);
                chk("d4_done", done4, (nwr == 3) ? 1 : 0);
                nwr++;
            end
        end
        chk("d4_accepted", nacc, 4);
        chk("d4_writes", nwr, 4);
        chk("d4_wc", word_count4, 4);
        chk("d4_ready_low", q.in_ready, 0);
        chk("d4_full_held", full4, 1);
        q.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Instruction encoder and program loader for the RISC-V core: the inverse of the IF/ID field decoder. It accepts decoded instruction fields (opcode, rs1, rs2, rd, funct3, funct7, immediate), packs them into 32-bit RV32I words by format, and writes them sequentially into instruction memory through a registered write port. It sits between a bench or host stimulus source and the instruction memory, so programs can be loaded before the fetch path runs them.

## Interface
- DEPTH, 64: instruction memory depth in words; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH): width of the word address.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  one-cycle pulse; begins a load session at word 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_last  in  1  bundle is the final instruction of the program.
- fmt  in  2  00 R, 01 I, 10 S, 11 U.
- opcode  in  7; rd, rs1, rs2  in  5 each; funct3  in  3; funct7  in  7; imm  in  32.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written this session.
- done  out  1  one-cycle pulse when the session ends.
- full  out  1  memory filled, held until next start.
- err  out  1  illegal-field flag (see Configuration).

## Operation
- FSM states: IDLE, LOAD, DONE. After reset: IDLE.
- IDLE/DONE + start → LOAD; wr_ptr, word_count, full, err cleared. start while in LOAD is ignored.
- in_ready = (state==LOAD) && !full.
- Handshake: bundle accepted on a rising edge with in_valid && in_ready. in_valid without in_ready holds; fields must stay stable until accepted.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - U: {imm[31:12], rd, opcode}
  - Unused fields are ignored.
- On accept: mem_wdata ← encoded word, mem_addr ← wr_ptr, mem_we ← 1, wr_ptr++, word_count++.
- Accepted in_last → DONE, done pulses.
- Write to address DEPTH-1 → full=1, DONE, done pulses. If in_last is set on the same word, only one done pulse is produced.
- wr_ptr never wraps, because in_ready drops once full is set.
- Reset outputs: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, done 0, full 0, err 0.

## Timing
- Latency of 1 cycle: mem_we, mem_addr and mem_wdata are valid for exactly one cycle, starting the cycle after the accepting edge.
- Throughput is one word per cycle with in_valid held high.
- done and full are asserted in the same cycle as the final mem_we.
- in_ready rises the cycle after the start edge.
- rst_n low at any time clears the block immediately and asynchronously to the reset values, including a write in flight: mem_we drops at once and no further write occurs.

## Configuration
- INSTR_ENC_CHECK_EN defined:
  - A bundle with opcode[1:0] != 2'b11 is accepted but not written: no mem_we, no pointer increment.
  - err is set sticky until the next start.
  - in_last on a rejected bundle still ends the session.
- Undefined: every accepted bundle is encoded and written as-is, and err is tied to 0.

## Test plan
- Reset then start. R-type rd=6, rs1=28, rs2=28, funct3=0, funct7=0, opcode=0x33 → mem_we for one cycle, addr 0, wdata 0x01CE0333, word_count 1.
- Back-to-back R-type bundles. Second bundle rs2=6, rs1=28, rd=6, opcode=0x33, in_last=1 → addr 1, wdata 0x006E0333, done pulses with that write, in_ready drops.
- I-type rd=1, rs1=0, funct3=0, imm=5, opcode=0x13 → wdata 0x00500093. S-type and U-type bundles produce correctly split immediates.
- DEPTH=4, stream 5 bundles with in_valid held high → writes to addresses 0..3, full=1 and done on the 4th write, 5th bundle never accepted, word_count=4.
- rst_n pulsed low mid-stream → all outputs return to reset values at once. A later start rewrites from address 0.
- With INSTR_ENC_CHECK_EN defined, bundle opcode=0x30 → no mem_we, err=1, next legal bundle is written to the same address.
